// File: rtl/pep_ks_common_param_pkg.sv
// Shared KS parameters plus the block-column bookkeeping and the tag carried
// alongside each output word of the KS output collector.
package pep_ks_common_param_pkg;

    localparam int LBX              = 3;
    localparam int LWE_K            = 9;
    localparam int TOTAL_BATCH_NB   = 2;
    localparam int TOTAL_BATCH_NB_W = 1;
    localparam int BPBS_ID_W        = 4;

    // Number of LBX-wide block columns needed to cover LWE_K coefficients.
    localparam int BCOL_NB = (LWE_K + LBX - 1) / LBX;
    localparam int BCOL_W  = (BCOL_NB > 1) ? $clog2(BCOL_NB) : 1;

    typedef struct packed {
        logic [TOTAL_BATCH_NB_W-1:0] batch_id;
        logic [BPBS_ID_W-1:0]        pbs_id;
        logic [BCOL_W-1:0]           bcol;
        logic                        last;
    } ks_outp_info_t;

    localparam int KS_OUTP_INFO_W = $bits(ks_outp_info_t);

    // Block-column index advance, wrapping BCOL_NB-1 back to 0.
    function automatic logic [BCOL_W-1:0] bcol_next(input logic [BCOL_W-1:0] b);
        if (b == BCOL_W'(BCOL_NB - 1)) begin
            bcol_next = '0;
        end else begin
            bcol_next = b + BCOL_W'(1);
        end
    endfunction

endpackage

// File: rtl/pep_ks_outp_fifo.sv
// Generic synchronous FIFO, WIDTH x DEPTH (DEPTH a power of 2, >= 2).
// Not fall-through: a word written at an edge is visible the cycle after.
// A write while full is dropped unless a read happens in the same cycle.
// Storage is not reset; only pointers and occupancy are.
module pep_ks_outp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             a_rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_wr, do_rd;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign do_rd   = rd_en & ~empty;
    assign do_wr   = wr_en & (~full | do_rd);
    assign rd_data = mem_q[rd_ptr_q];

    // Pointer and occupancy update; pointers wrap naturally modulo DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_wr);
        rd_ptr_d = rd_ptr_q + AW'(do_rd);
        cnt_d    = cnt_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        mem_d    = mem_q;
        if (do_wr) begin
            mem_d[wr_ptr_q] = wr_data;
        end
    end

    // Control state, cleared by reset.
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Word storage, no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/pep_ks_outp_collect.sv
// KS output collector: deskews the LBX systolic columns of the mult array,
// mod-switches OP_W -> OUT_W, tags each word with batch/pbs/block-column and
// buffers it in an output FIFO. The input side cannot be stalled, so a write
// into a full FIFO is dropped and flagged in error[0]; column misalignment or
// disagreeing column tags are flagged in error[1]. Both flags are sticky.
// Define PEP_KS_OUTP_ROUND_EN for round-half-up mod-switch (default: floor).
module pep_ks_outp_collect
    import pep_ks_common_param_pkg::*;
#(
    parameter int OP_W       = 64,
    parameter int OUT_W      = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                             clk,
    input  logic                             a_rst_n,
    input  logic [LBX*OP_W-1:0]              mult_outp_data,
    input  logic [LBX-1:0]                   mult_outp_avail,
    input  logic [LBX-1:0]                   mult_outp_last_pbs,
    input  logic [LBX*TOTAL_BATCH_NB_W-1:0]  mult_outp_batch_id,
    output logic [LBX*OUT_W-1:0]             outp_data,
    output logic [TOTAL_BATCH_NB_W-1:0]      outp_batch_id,
    output logic [BPBS_ID_W-1:0]             outp_pbs_id,
    output logic [BCOL_W-1:0]                outp_bcol,
    output logic                             outp_last,
    output logic                             outp_vld,
    input  logic                             outp_rdy,
    output logic [1:0]                       error
);

    localparam int TBW    = TOTAL_BATCH_NB_W;
    localparam int SH     = OP_W - OUT_W;
    localparam int FIFO_W = LBX * OUT_W + KS_OUTP_INFO_W;

    // Deskewed (combinationally aligned) column view.
    logic [LBX-1:0]           sk_avail;
    logic [LBX-1:0]           sk_last;
    logic [LBX-1:0][TBW-1:0]  sk_batch;
    logic [LBX-1:0][OP_W-1:0] sk_data;

    // Registered aligned word.
    logic [LBX-1:0]           al_avail_q, al_avail_d;
    logic [LBX-1:0]           al_last_q, al_last_d;
    logic [LBX-1:0][TBW-1:0]  al_batch_q, al_batch_d;
    logic [LBX-1:0][OP_W-1:0] al_data_q, al_data_d;

    logic [BPBS_ID_W-1:0]     pbs_id_q, pbs_id_d;
    logic [BCOL_W-1:0]        bcol_q [TOTAL_BATCH_NB];
    logic [BCOL_W-1:0]        bcol_d [TOTAL_BATCH_NB];
    logic [1:0]               err_q, err_d;

    logic                     word_en, w_last, skew_err, ovf;
    logic [TBW-1:0]           w_batch;
    logic [BCOL_W-1:0]        cur_bcol;
    logic [LBX*OUT_W-1:0]     w_data;
    ks_outp_info_t            w_info, r_info;
    logic [FIFO_W-1:0]        fifo_rd_data;
    logic                     fifo_full, fifo_empty;

    // Column x arrives x cycles after column 0, so it is delayed LBX-1-x cycles.
    for (genvar gx = 0; gx < LBX; gx++) begin : g_col
        localparam int DLY = LBX - 1 - gx;
        if (DLY == 0) begin : g_direct
            assign sk_avail[gx] = mult_outp_avail[gx];
            assign sk_last[gx]  = mult_outp_last_pbs[gx];
            assign sk_batch[gx] = mult_outp_batch_id[gx*TBW +: TBW];
            assign sk_data[gx]  = mult_outp_data[gx*OP_W +: OP_W];
        end else begin : g_dly
            logic [DLY-1:0]           avail_q, avail_d;
            logic [DLY-1:0]           last_q, last_d;
            logic [DLY-1:0][TBW-1:0]  batch_q, batch_d;
            logic [DLY-1:0][OP_W-1:0] data_q, data_d;

            // Shift line: stage 0 takes the live column input.
            always_comb begin
                avail_d[0] = mult_outp_avail[gx];
                last_d[0]  = mult_outp_last_pbs[gx];
                batch_d[0] = mult_outp_batch_id[gx*TBW +: TBW];
                data_d[0]  = mult_outp_data[gx*OP_W +: OP_W];
                for (int s = 1; s < DLY; s++) begin
                    avail_d[s] = avail_q[s-1];
                    last_d[s]  = last_q[s-1];
                    batch_d[s] = batch_q[s-1];
                    data_d[s]  = data_q[s-1];
                end
            end

            // Valid bits are reset so no stale word survives a reset.
            always_ff @(posedge clk or negedge a_rst_n) begin
                if (!a_rst_n) begin
                    avail_q <= '0;
                end else begin
                    avail_q <= avail_d;
                end
            end

            // Payload of the delay line, no reset.
            always_ff @(posedge clk) begin
                last_q  <= last_d;
                batch_q <= batch_d;
                data_q  <= data_d;
            end

            assign sk_avail[gx] = avail_q[DLY-1];
            assign sk_last[gx]  = last_q[DLY-1];
            assign sk_batch[gx] = batch_q[DLY-1];
            assign sk_data[gx]  = data_q[DLY-1];
        end
    end

    // Aligned-word register inputs.
    always_comb begin
        al_avail_d = sk_avail;
        al_last_d  = sk_last;
        al_batch_d = sk_batch;
        al_data_d  = sk_data;
    end

    // Aligned valid vector, cleared by reset.
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            al_avail_q <= '0;
        end else begin
            al_avail_q <= al_avail_d;
        end
    end

    // Aligned payload, no reset.
    always_ff @(posedge clk) begin
        al_last_q  <= al_last_d;
        al_batch_q <= al_batch_d;
        al_data_q  <= al_data_d;
    end

    // Skew check; column 0 decides whether a word exists and supplies its tags.
    always_comb begin
        logic fld_mis;
        fld_mis = 1'b0;
        for (int x = 1; x < LBX; x++) begin
            if ((al_last_q[x] != al_last_q[0]) || (al_batch_q[x] != al_batch_q[0])) begin
                fld_mis = 1'b1;
            end
        end
        skew_err = ((|al_avail_q) & ~(&al_avail_q)) | ((&al_avail_q) & fld_mis);
        word_en  = al_avail_q[0];
        w_last   = al_last_q[0];
        w_batch  = al_batch_q[0];
    end

    // Per-coefficient mod-switch OP_W -> OUT_W.
    for (genvar gx = 0; gx < LBX; gx++) begin : g_msw
`ifdef PEP_KS_OUTP_ROUND_EN
        if (SH > 0) begin : g_rnd
            logic [OP_W-1:0] sum;
            assign sum = al_data_q[gx] + (OP_W'(1) << (SH - 1));
            assign w_data[gx*OUT_W +: OUT_W] = sum[OP_W-1 -: OUT_W];
        end else begin : g_same
            assign w_data[gx*OUT_W +: OUT_W] = al_data_q[gx][OP_W-1 -: OUT_W];
        end
`else
        assign w_data[gx*OUT_W +: OUT_W] = al_data_q[gx][OP_W-1 -: OUT_W];
        if (SH > 0) begin : g_lsb
            logic unused_lsb;
            assign unused_lsb = ^al_data_q[gx][SH-1:0];
        end
`endif
    end

    // Tag construction and counter advance; counters move even if the FIFO drops the word.
    always_comb begin
        cur_bcol = '0;
        for (int b = 0; b < TOTAL_BATCH_NB; b++) begin
            if (w_batch == TBW'(b)) begin
                cur_bcol = bcol_q[b];
            end
        end

        w_info.batch_id = w_batch;
        w_info.pbs_id   = pbs_id_q;
        w_info.bcol     = cur_bcol;
        w_info.last     = w_last & (cur_bcol == BCOL_W'(BCOL_NB - 1));

        pbs_id_d = pbs_id_q;
        bcol_d   = bcol_q;
        if (word_en) begin
            pbs_id_d = w_last ? '0 : (pbs_id_q + BPBS_ID_W'(1));
            for (int b = 0; b < TOTAL_BATCH_NB; b++) begin
                if (w_last && (w_batch == TBW'(b))) begin
                    bcol_d[b] = bcol_next(bcol_q[b]);
                end
            end
        end

        // A write landing on a full FIFO is only lost when no read frees a slot.
        ovf   = word_en & fifo_full & ~(outp_rdy & ~fifo_empty);
        err_d = err_q | {skew_err, ovf};
    end

    // Counters and sticky error flags.
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            pbs_id_q <= '0;
            err_q    <= '0;
            for (int b = 0; b < TOTAL_BATCH_NB; b++) begin
                bcol_q[b] <= '0;
            end
        end else begin
            pbs_id_q <= pbs_id_d;
            err_q    <= err_d;
            bcol_q   <= bcol_d;
        end
    end

    pep_ks_outp_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .a_rst_n (a_rst_n),
        .wr_en   (word_en),
        .wr_data ({w_data, w_info}),
        .rd_en   (outp_rdy),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign r_info        = ks_outp_info_t'(fifo_rd_data[KS_OUTP_INFO_W-1:0]);
    assign outp_data     = fifo_rd_data[FIFO_W-1 -: LBX*OUT_W];
    assign outp_batch_id = r_info.batch_id;
    assign outp_pbs_id   = r_info.pbs_id;
    assign outp_bcol     = r_info.bcol;
    assign outp_last     = r_info.last;
    assign outp_vld      = ~fifo_empty;
    assign error         = err_q;

endmodule

// File: tb/tb_pep_ks_outp_collect.sv
`timescale 1ns/1ps
module tb_pep_ks_outp_collect;
    import pep_ks_common_param_pkg::*;

    localparam int OP_W       = 64;
    localparam int OUT_W      = 32;
    localparam int FIFO_DEPTH = 4;
    localparam int TBW        = TOTAL_BATCH_NB_W;
`ifdef PEP_KS_OUTP_ROUND_EN
    localparam logic [31:0] LAT_C0 = 32'h2;
`else
    localparam logic [31:0] LAT_C0 = 32'h1;
`endif

    logic                            clk = 1'b0;
    logic                            a_rst_n;
    logic [LBX*OP_W-1:0]             mult_outp_data;
    logic [LBX-1:0]                  mult_outp_avail;
    logic [LBX-1:0]                  mult_outp_last_pbs;
    logic [LBX*TBW-1:0]              mult_outp_batch_id;
    logic [LBX*OUT_W-1:0]            outp_data;
    logic [TBW-1:0]                  outp_batch_id;
    logic [BPBS_ID_W-1:0]            outp_pbs_id;
    logic [BCOL_W-1:0]               outp_bcol;
    logic                            outp_last;
    logic                            outp_vld;
    logic                            outp_rdy;
    logic [1:0]                      error;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pep_ks_outp_collect #(
        .OP_W       (OP_W),
        .OUT_W      (OUT_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk                (clk),
        .a_rst_n            (a_rst_n),
        .mult_outp_data     (mult_outp_data),
        .mult_outp_avail    (mult_outp_avail),
        .mult_outp_last_pbs (mult_outp_last_pbs),
        .mult_outp_batch_id (mult_outp_batch_id),
        .outp_data          (outp_data),
        .outp_batch_id      (outp_batch_id),
        .outp_pbs_id        (outp_pbs_id),
        .outp_bcol          (outp_bcol),
        .outp_last          (outp_last),
        .outp_vld           (outp_vld),
        .outp_rdy           (outp_rdy),
        .error              (error)
    );

    // Skew generator: h_*[k] is the word presented on column 0 k cycles ago.
    logic        h_av    [LBX+1];
    logic        h_last  [LBX+1];
    logic [TBW-1:0] h_batch [LBX+1];
    logic [63:0] h_base  [LBX+1];
    logic        late2 = 1'b0;

    typedef struct packed {
        logic                 last;
        logic [TBW-1:0]       batch;
        logic [63:0]          base;
        logic [BCOL_W-1:0]    e_bcol;
        logic [BPBS_ID_W-1:0] e_pbs;
        logic                 e_last;
    } vec_t;

    vec_t tbl [13];

    function automatic logic [LBX*OUT_W-1:0] exp_data(input logic [63:0] base);
        logic [63:0] d;
        logic [64:0] s;
        exp_data = '0;
        for (int x = 0; x < LBX; x++) begin
            d = base + (64'(x) << 32);
            s = {1'b0, d} + 65'h8000_0000;
`ifdef PEP_KS_OUTP_ROUND_EN
            exp_data[x*OUT_W +: OUT_W] = s[63:32];
`else
            exp_data[x*OUT_W +: OUT_W] = d[63:32];
`endif
        end
    endfunction

    function automatic logic [63:0] wbase(input int k);
        wbase = ((64'(k) + 64'd1) << 36) | 64'h0000_0005_0000_0000;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive_cols();
        int idx;
        for (int x = 0; x < LBX; x++) begin
            idx = x;
            if (late2 && x == LBX - 1) idx = x + 1;
            mult_outp_avail[x]                 = h_av[idx];
            mult_outp_last_pbs[x]              = h_last[idx];
            mult_outp_batch_id[x*TBW +: TBW]   = h_batch[idx];
            mult_outp_data[x*OP_W +: OP_W]     = h_base[idx] + (64'(x) << 32);
        end
    endtask

    task automatic clear_hist();
        for (int i = 0; i <= LBX; i++) begin
            h_av[i] = 1'b0; h_last[i] = 1'b0; h_batch[i] = '0; h_base[i] = '0;
        end
        late2 = 1'b0;
        drive_cols();
    endtask

    // Present one word (or a bubble) on column 0 for one cycle.
    task automatic present(input logic av, input logic last, input logic [TBW-1:0] b,
                           input logic [63:0] base);
        for (int i = LBX; i > 0; i--) begin
            h_av[i] = h_av[i-1]; h_last[i] = h_last[i-1];
            h_batch[i] = h_batch[i-1]; h_base[i] = h_base[i-1];
        end
        h_av[0] = av; h_last[0] = last; h_batch[0] = b; h_base[0] = base;
        drive_cols();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        present(1'b0, 1'b0, '0, 64'h0);
    endtask

    task automatic wait_vld(input string name);
        int k;
        k = 0;
        while (outp_vld !== 1'b1 && k < 12) begin
            idle();
            k++;
        end
        check({name, "_vld"}, 128'(outp_vld), 128'(1));
    endtask

    task automatic check_word(input string name, input logic [63:0] base, input logic [TBW-1:0] b,
                              input logic [BPBS_ID_W-1:0] p, input logic [BCOL_W-1:0] c,
                              input logic l);
        check({name, "_data"},  128'(outp_data),     128'(exp_data(base)));
        check({name, "_batch"}, 128'(outp_batch_id), 128'(b));
        check({name, "_pbs"},   128'(outp_pbs_id),   128'(p));
        check({name, "_bcol"},  128'(outp_bcol),     128'(c));
        check({name, "_last"},  128'(outp_last),     128'(l));
    endtask

    task automatic do_reset();
        a_rst_n  = 1'b0;
        outp_rdy = 1'b1;
        clear_hist();
        repeat (2) @(posedge clk);
        #1;
        a_rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        //             last  batch base                    bcol  pbs   last
        tbl[0]  = '{1'b0, 1'b0, 64'h0123_4567_89AB_CDEF, 2'd0, 4'd0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 64'hFFFF_FFFF_8000_0000, 2'd0, 4'd1, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 64'h0000_0002_7FFF_FFFF, 2'd1, 4'd0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 64'h0000_0000_0000_0000, 2'd1, 4'd1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 64'hDEAD_BEEF_FFFF_FFFF, 2'd2, 4'd0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 64'h1234_5678_8000_0001, 2'd2, 4'd1, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, 64'h0000_00A0_0000_0000, 2'd0, 4'd0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 64'h0000_00B1_4000_0000, 2'd0, 4'd0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 64'h0000_00C2_C000_0000, 2'd1, 4'd0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 64'h7FFF_FFFF_7FFF_FFFF, 2'd1, 4'd0, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 64'h8000_0000_8000_0000, 2'd1, 4'd1, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 64'h5555_5555_AAAA_AAAA, 2'd2, 4'd0, 1'b1};
        tbl[12] = '{1'b1, 1'b0, 64'hCAFE_F00D_0000_0001, 2'd2, 4'd0, 1'b1};

        a_rst_n  = 1'b0;
        outp_rdy = 1'b1;
        clear_hist();
        #2;
        check("rst_vld", 128'(outp_vld), 128'(0));
        check("rst_err", 128'(error), 128'(0));
        repeat (3) @(posedge clk);
        #1;
        a_rst_n = 1'b1;

        // Skew + latency: column 0 strobe at cycle 10, output valid at cycle 14.
        while (cyc < 10) idle();
        present(1'b1, 1'b0, 1'b0, 64'h0000_0001_8000_0000);
        idle();
        idle();
        check("lat_early_vld", 128'(outp_vld), 128'(0));
        idle();
        check("lat_vld", 128'(outp_vld), 128'(1));
        check("lat_col0", 128'(outp_data[31:0]), 128'(LAT_C0));
        check_word("lat", 64'h0000_0001_8000_0000, 1'b0, 4'd0, 2'd0, 1'b0);
        check("lat_err", 128'(error), 128'(0));

        // Column walk and batch interleave.
        do_reset();
        for (int i = 0; i < 13; i++) begin
            present(1'b1, tbl[i].last, tbl[i].batch, tbl[i].base);
            wait_vld($sformatf("tbl%0d", i));
            check_word($sformatf("tbl%0d", i), tbl[i].base, tbl[i].batch,
                       tbl[i].e_pbs, tbl[i].e_bcol, tbl[i].e_last);
        end
        check("tbl_err", 128'(error), 128'(0));

        // Overflow: 5 words into a 4-deep FIFO with no reader.
        do_reset();
        outp_rdy = 1'b0;
        for (int k = 0; k < 5; k++) present(1'b1, 1'b0, 1'b0, wbase(k));
        repeat (6) idle();
        check("ovf_err", 128'(error), 128'(2'b01));
        check("ovf_hold_vld", 128'(outp_vld), 128'(1));
        check("ovf_hold_data", 128'(outp_data), 128'(exp_data(wbase(0))));
        outp_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_vld($sformatf("ovf_rd%0d", k));
            check($sformatf("ovf_rd%0d_data", k), 128'(outp_data), 128'(exp_data(wbase(k))));
            check($sformatf("ovf_rd%0d_pbs", k), 128'(outp_pbs_id), 128'(k));
            idle();
        end
        check("ovf_drained_vld", 128'(outp_vld), 128'(0));
        present(1'b1, 1'b1, 1'b0, wbase(9));
        wait_vld("ovf_next");
        check("ovf_next_pbs", 128'(outp_pbs_id), 128'(5));
        check("ovf_err_sticky", 128'(error), 128'(2'b01));

        // Full FIFO with a read and a write in the same cycle.
        do_reset();
        outp_rdy = 1'b0;
        for (int k = 0; k < 4; k++) present(1'b1, 1'b0, 1'b0, wbase(k));
        repeat (4) idle();
        check("frw_full_err", 128'(error), 128'(0));
        present(1'b1, 1'b0, 1'b0, wbase(4));
        idle();
        idle();
        outp_rdy = 1'b1;
        idle();
        outp_rdy = 1'b0;
        check("frw_err", 128'(error), 128'(0));
        check("frw_head_pbs", 128'(outp_pbs_id), 128'(1));
        outp_rdy = 1'b1;
        for (int k = 1; k < 5; k++) begin
            wait_vld($sformatf("frw_rd%0d", k));
            check($sformatf("frw_rd%0d_data", k), 128'(outp_data), 128'(exp_data(wbase(k))));
            check($sformatf("frw_rd%0d_pbs", k), 128'(outp_pbs_id), 128'(k));
            idle();
        end
        check("frw_drained_vld", 128'(outp_vld), 128'(0));
        check("frw_err_end", 128'(error), 128'(0));

        // Column 2 one cycle late.
        do_reset();
        late2 = 1'b1;
        present(1'b1, 1'b1, 1'b0, wbase(3));
        wait_vld("skw");
        check("skw_err", 128'(error), 128'(2'b10));
        check("skw_pbs", 128'(outp_pbs_id), 128'(0));
        check("skw_bcol", 128'(outp_bcol), 128'(0));
        idle();
        idle();
        check("skw_single_word", 128'(outp_vld), 128'(0));
        idle();
        late2 = 1'b0;
        present(1'b1, 1'b0, 1'b0, wbase(6));
        wait_vld("skw_good");
        check_word("skw_good", wbase(6), 1'b0, 4'd0, 2'd1, 1'b0);
        check("skw_err_sticky", 128'(error), 128'(2'b10));
        do_reset();
        check("skw_err_cleared", 128'(error), 128'(0));

        // Reset with 3 words buffered and 1 still in flight.
        outp_rdy = 1'b0;
        present(1'b1, 1'b1, 1'b0, wbase(0));
        present(1'b1, 1'b0, 1'b1, wbase(1));
        present(1'b1, 1'b0, 1'b0, wbase(2));
        present(1'b1, 1'b0, 1'b0, wbase(3));
        idle();
        idle();
        check("rstm_pre_vld", 128'(outp_vld), 128'(1));
        a_rst_n = 1'b0;
        clear_hist();
        #1;
        check("rstm_async_vld", 128'(outp_vld), 128'(0));
        repeat (2) @(posedge clk);
        #1;
        a_rst_n  = 1'b1;
        outp_rdy = 1'b1;
        check("rstm_post_vld", 128'(outp_vld), 128'(0));
        check("rstm_post_err", 128'(error), 128'(0));
        repeat (5) idle();
        check("rstm_no_partial", 128'(outp_vld), 128'(0));
        present(1'b1, 1'b0, 1'b0, wbase(7));
        wait_vld("rstm_next");
        check_word("rstm_next", wbase(7), 1'b0, 4'd0, 2'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
